sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator_if.sv | 25 ++
 rtl/sequence_generator.sv | 108 ++++++++++
 tb/tb_sequence_generator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sequence_generator_if.sv
// Control and serial-output bundle for sequence_generator.
// master drives START/ABORT/PATTERN/REPEAT; slave (the generator) drives the serial side.
interface sequence_generator_if #(
  parameter int PAT_W = 5
);
  logic             START;
  logic             ABORT;
  logic [PAT_W-1:0] PATTERN;
  logic [3:0]       REPEAT;
  logic             Dout;
  logic             VALID;
  logic             BUSY;
  logic             DONE;
  logic [2:0]       state;

  modport master (
    output START, ABORT, PATTERN, REPEAT,
    input  Dout, VALID, BUSY, DONE, state
  );

  modport slave (
    input  START, ABORT, PATTERN, REPEAT,
    output Dout, VALID, BUSY, DONE, state
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial burst generator: sends PATTERN MSB-first REPEAT+1 times, then a one-cycle DONE.
// First bit one cycle after START; SEQGEN_GAP_EN inserts GAP_LEN idle cycles between repetitions.
module sequence_generator #(
  parameter int PAT_W   = 5,
  parameter int GAP_LEN = 2
) (
  input logic                 CLK,
  input logic                 RESET_N,
  sequence_generator_if.slave bus
);
  localparam int CNT_W = $clog2(PAT_W);

  if (PAT_W < 2 || PAT_W > 16 || GAP_LEN < 1 || GAP_LEN > 15) begin : g_bad_param
    $error("sequence_generator: PAT_W or GAP_LEN out of range");
  end

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SEND = 3'b001,
    GAP  = 3'b010,
    FIN  = 3'b011
  } state_t;

  state_t           state_q;
  logic [PAT_W-1:0] shreg_q;
  logic [PAT_W-1:0] pat_q;
  logic [3:0]       rep_q;
  logic [CNT_W-1:0] bit_q;
  logic             last_bit;
`ifdef SEQGEN_GAP_EN
  logic [3:0]       gap_q;
`endif

  assign last_bit = (bit_q == CNT_W'(PAT_W - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      shreg_q <= '0;
      pat_q   <= '0;
      rep_q   <= '0;
      bit_q   <= '0;
`ifdef SEQGEN_GAP_EN
      gap_q   <= '0;
`endif
    end else if (bus.ABORT) begin
      // Cancel wins over everything, including a START in IDLE; no DONE is produced.
      state_q <= IDLE;
      bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            shreg_q <= bus.PATTERN;
            pat_q   <= bus.PATTERN;
            rep_q   <= bus.REPEAT;
            bit_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (last_bit) begin
            bit_q <= '0;
            if (rep_q != 4'd0) begin
              rep_q   <= rep_q - 4'd1;
              shreg_q <= pat_q;
`ifdef SEQGEN_GAP_EN
              gap_q   <= '0;
              state_q <= GAP;
`else
              state_q <= SEND;
`endif
            end else begin
              shreg_q <= '0;
              state_q <= FIN;
            end
          end else begin
            shreg_q <= {shreg_q[PAT_W-2:0], 1'b0};
            bit_q   <= bit_q + CNT_W'(1);
          end
        end
`ifdef SEQGEN_GAP_EN
        GAP: begin
          if (gap_q == 4'(GAP_LEN - 1)) begin
            state_q <= SEND;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
`endif
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, so reset clears them without waiting for a clock.
  assign bus.Dout  = (state_q == SEND) & shreg_q[PAT_W-1];
  assign bus.VALID = (state_q == SEND);
`ifdef SEQGEN_GAP_EN
  assign bus.BUSY  = (state_q == SEND) || (state_q == GAP);
`else
  assign bus.BUSY  = (state_q == SEND);
`endif
  assign bus.DONE  = (state_q == FIN);
  assign bus.state = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: expected Dout/VALID streams are hand-written constants.
module tb_sequence_generator;
  logic CLK = 1'b0;
  logic RESET_N;
  int   n_chk = 0;
  int   n_err = 0;

  sequence_generator_if #(.PAT_W(5)) bus ();

  sequence_generator #(.PAT_W(5), .GAP_LEN(2)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b exp %b", tag, got[6:0], exp[6:0]);
    end
  endtask

  // Status vector {state, Dout, VALID, BUSY, DONE}.
  function automatic logic [31:0] status();
    return {25'd0, bus.state, bus.Dout, bus.VALID, bus.BUSY, bus.DONE};
  endfunction

  function automatic logic [31:0] st(input logic [2:0] s, input logic d, input logic v,
                                     input logic b, input logic dn);
    return {25'd0, s, d, v, b, dn};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic launch(input logic [4:0] pat, input logic [3:0] rep);
    bus.PATTERN = pat;
    bus.REPEAT  = rep;
    bus.START   = 1'b1;
  endtask

  // Runs n cycles from the START edge; dv/vv hold Dout/VALID per cycle, cycle 1 in bit n-1.
  // Inputs are scrambled after acceptance to show the burst uses only captured values.
  task automatic expect_burst(input string tag, input logic [31:0] dv, input logic [31:0] vv,
                              input int n);
    for (int c = 1; c <= n; c++) begin
      tick();
      if (c == 1) begin
        bus.START   = 1'b0;
        bus.PATTERN = ~bus.PATTERN;
        bus.REPEAT  = 4'hF;
      end
      chk($sformatf("%s_c%0d", tag, c), status(),
          st(vv[n-c] ? 3'b001 : 3'b010, dv[n-c], vv[n-c], 1'b1, 1'b0));
    end
    tick();
    chk({tag, "_fin"}, status(), st(3'b011, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    chk({tag, "_idle"}, status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    RESET_N     = 1'b0;
    bus.START   = 1'b0;
    bus.ABORT   = 1'b0;
    bus.PATTERN = 5'b11011;
    bus.REPEAT  = 4'd0;
    repeat (2) @(negedge CLK);
    chk("reset", status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));

    // Start requested together with reset release: accepted on the very first edge.
    RESET_N = 1'b1;
    launch(5'b11011, 4'd0);
    expect_burst("single", 32'b11011, 32'b11111, 5);

    launch(5'b10010, 4'd0);
    expect_burst("single2", 32'b10010, 32'b11111, 5);

`ifdef SEQGEN_GAP_EN
    launch(5'b11011, 4'd2);
    expect_burst("rep2", 32'b1101100110110011011, 32'b1111100111110011111, 19);
    launch(5'b10010, 4'd1);
    expect_burst("rep1", 32'b100100010010, 32'b111110011111, 12);
`else
    launch(5'b11011, 4'd2);
    expect_burst("rep2", 32'b110111101111011, 32'h7FFF, 15);
    launch(5'b10010, 4'd1);
    expect_burst("rep1", 32'b1001010010, 32'h3FF, 10);
`endif

    // START and new PATTERN during SEND are ignored; original 11011 completes.
    launch(5'b11011, 4'd0);
    tick();
    bus.START = 1'b0;
    chk("ign_c1", status(), st(3'b001, 1'b1, 1'b1, 1'b1, 1'b0));
    bus.START   = 1'b1;
    bus.PATTERN = 5'b10101;
    tick();
    chk("ign_c2", status(), st(3'b001, 1'b1, 1'b1, 1'b1, 1'b0));
    tick();
    chk("ign_c3", status(), st(3'b001, 1'b0, 1'b1, 1'b1, 1'b0));
    tick();
    chk("ign_c4", status(), st(3'b001, 1'b1, 1'b1, 1'b1, 1'b0));
    tick();
    chk("ign_c5", status(), st(3'b001, 1'b1, 1'b1, 1'b1, 1'b0));
    bus.START = 1'b0;
    tick();
    chk("ign_fin", status(), st(3'b011, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("ign_idle", status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));

    // ABORT at cycle 3, restart at cycle 4.
    launch(5'b11011, 4'd0);
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    chk("abt_c3", status(), st(3'b001, 1'b0, 1'b1, 1'b1, 1'b0));
    bus.ABORT = 1'b1;
    tick();
    chk("abt_c4", status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.ABORT = 1'b0;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("abt_c5", status(), st(3'b001, 1'b1, 1'b1, 1'b1, 1'b0));
    // ABORT mid-burst again, then ABORT with START in IDLE must stay idle.
    bus.ABORT = 1'b1;
    tick();
    chk("abt_c6", status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.START = 1'b1;
    tick();
    chk("abt_start", status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    tick();
    chk("abt_quiet", status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset asserted between edges mid-SEND clears outputs immediately.
    launch(5'b11011, 4'd0);
    tick();
    bus.START = 1'b0;
    tick();
    chk("rst_c2", status(), st(3'b001, 1'b1, 1'b1, 1'b1, 1'b0));
    #1 RESET_N = 1'b0;
    #1 chk("rst_now", status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    tick();
    RESET_N = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("rst_after%0d", c), status(), st(3'b000, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    launch(5'b11011, 4'd0);
    expect_burst("post_rst", 32'b11011, 32'b11111, 5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
